sobel_wrapper: RTL and testbench



---
 rtl/sobel_wrapper_if.sv | 9 +
 rtl/sobel_wrapper.sv | 46 ++++
 tb/tb_sobel_wrapper.sv | 117 +++++++++++
 3 files changed

// File: rtl/sobel_wrapper_if.sv
// sobel_wrapper_if: window/start request and registered edge-magnitude result.
interface sobel_wrapper_if #(parameter int PIXEL_W = 8);
    logic               start_calculations;
    logic [PIXEL_W-1:0] windowBuffer [0:8];
    logic [PIXEL_W-1:0] g;
    logic               calc_done;
    modport master (output start_calculations, windowBuffer, input g, calc_done);
    modport slave  (input start_calculations, windowBuffer, output g, calc_done);
endinterface

// File: rtl/sobel_wrapper.sv
// sobel_wrapper: 2-stage Sobel kernel, registers Gx/Gy then saturated |Gx|+|Gy|.
module sobel_wrapper #(parameter int PIXEL_W = 8) (
    input logic           clk,
    input logic           n_rst,
    sobel_wrapper_if.slave bus
);
    localparam int SW = PIXEL_W + 2;
    localparam int GW = PIXEL_W + 3;
    logic        [SW-1:0]      sx_p, sx_n, sy_p, sy_n;
    logic signed [GW-1:0]      gx_d, gy_d, gx_q, gy_q;
    logic        [GW-1:0]      ax, ay, mag;
    logic        [PIXEL_W-1:0] g_d, g_q;
    logic                      v1_q, done_q;
    always_comb begin
        sx_p = SW'(bus.windowBuffer[2]) + (SW'(bus.windowBuffer[5]) << 1) + SW'(bus.windowBuffer[8]);
        sx_n = SW'(bus.windowBuffer[0]) + (SW'(bus.windowBuffer[3]) << 1) + SW'(bus.windowBuffer[6]);
        sy_p = SW'(bus.windowBuffer[6]) + (SW'(bus.windowBuffer[7]) << 1) + SW'(bus.windowBuffer[8]);
        sy_n = SW'(bus.windowBuffer[0]) + (SW'(bus.windowBuffer[1]) << 1) + SW'(bus.windowBuffer[2]);
        gx_d = signed'(GW'(sx_p)) - signed'(GW'(sx_n));
        gy_d = signed'(GW'(sy_p)) - signed'(GW'(sy_n));
        // |G| <= 4*(2^P-1), so the sum of magnitudes still fits in GW bits
        ax   = gx_q[GW-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
        ay   = gy_q[GW-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag  = ax + ay;
        g_d  = (mag > GW'({PIXEL_W{1'b1}})) ? '1 : mag[PIXEL_W-1:0];
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gx_q   <= '0;
            gy_q   <= '0;
            v1_q   <= 1'b0;
            g_q    <= '0;
            done_q <= 1'b0;
        end else begin
            v1_q   <= bus.start_calculations;
            done_q <= v1_q;
            if (bus.start_calculations) begin
                gx_q <= gx_d;
                gy_q <= gy_d;
            end
            if (v1_q) g_q <= g_d;
        end
    end
    assign bus.g         = g_q;
    assign bus.calc_done = done_q;
endmodule

// File: tb/tb_sobel_wrapper.sv
// tb_sobel_wrapper: directed windows with hand-computed edge magnitudes.
module tb_sobel_wrapper;
    logic clk;
    logic n_rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    sobel_wrapper_if #(.PIXEL_W(8)) bus ();
    sobel_wrapper #(.PIXEL_W(8)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // start at edge N, result and done visible after edge N+1, done gone after N+2
    task automatic calc(input string tag, input int exp);
        bus.start_calculations = 1'b1;
        tick();
        chk({tag, "_done_early"}, int'(bus.calc_done), 0);
        bus.start_calculations = 1'b0;
        tick();
        chk({tag, "_done"}, int'(bus.calc_done), 1);
        chk({tag, "_g"}, int'(bus.g), exp);
        tick();
        chk({tag, "_done_off"}, int'(bus.calc_done), 0);
        chk({tag, "_g_hold"}, int'(bus.g), exp);
    endtask
    initial begin
        n_rst = 1'b0;
        bus.start_calculations = 1'b0;
        bus.windowBuffer = '{default: 8'd0};
        #1;
        chk("rst_g", int'(bus.g), 0);
        chk("rst_done", int'(bus.calc_done), 0);
        tick();
        tick();
        chk("rst_g2", int'(bus.g), 0);
        chk("rst_done2", int'(bus.calc_done), 0);
        n_rst = 1'b1;
        tick();
        chk("post_rst_g", int'(bus.g), 0);
        chk("post_rst_done", int'(bus.calc_done), 0);
        calc("zero", 0);
        bus.windowBuffer = '{8'd50, 8'd255, 8'd250, 8'd100, 8'd0, 8'd200, 8'd100, 8'd255, 8'd255};
        calc("sat_pos", 255);
        bus.windowBuffer = '{default: 8'd255};
        calc("flat", 0);
        bus.windowBuffer = '{8'd255, 8'd255, 8'd0, 8'd155, 8'd255, 8'd205, 8'd255, 8'd255, 8'd5};
        calc("sat_neg", 255);
        bus.windowBuffer = '{8'd40, 8'd255, 8'd32, 8'd255, 8'd255, 8'd100, 8'd0, 8'd255, 8'd1};
        calc("sat_neg2", 255);
        bus.windowBuffer = '{default: 8'd255};
        tick();
        chk("nostart_done", int'(bus.calc_done), 0);
        tick();
        chk("nostart_done2", int'(bus.calc_done), 0);
        chk("nostart_g", int'(bus.g), 255);
        bus.windowBuffer = '{8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd10};
        calc("gx60", 60);
        bus.windowBuffer = '{8'd10, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0};
        calc("gxm60", 60);
        bus.windowBuffer = '{8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        calc("gym20", 20);
        bus.windowBuffer = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd5, 8'd0};
        calc("mix30", 30);
        bus.windowBuffer = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0};
        calc("b254", 254);
        bus.windowBuffer = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0, 8'd0};
        calc("b256", 255);
        // back-to-back: 60, 20, 30 in order
        bus.start_calculations = 1'b1;
        bus.windowBuffer = '{8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd10};
        tick();
        bus.windowBuffer = '{8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tick();
        chk("b2b_done1", int'(bus.calc_done), 1);
        chk("b2b_g1", int'(bus.g), 60);
        bus.windowBuffer = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd5, 8'd0};
        tick();
        chk("b2b_done2", int'(bus.calc_done), 1);
        chk("b2b_g2", int'(bus.g), 20);
        bus.start_calculations = 1'b0;
        bus.windowBuffer = '{default: 8'd0};
        tick();
        chk("b2b_done3", int'(bus.calc_done), 1);
        chk("b2b_g3", int'(bus.g), 30);
        tick();
        chk("b2b_done_off", int'(bus.calc_done), 0);
        // reset between start edge and result edge discards the calculation
        bus.windowBuffer = '{8'd50, 8'd255, 8'd250, 8'd100, 8'd0, 8'd200, 8'd100, 8'd255, 8'd255};
        bus.start_calculations = 1'b1;
        tick();
        bus.start_calculations = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_g", int'(bus.g), 0);
        chk("mid_rst_done", int'(bus.calc_done), 0);
        #2;
        n_rst = 1'b1;
        tick();
        chk("after_rst_done", int'(bus.calc_done), 0);
        chk("after_rst_g", int'(bus.g), 0);
        tick();
        chk("after_rst_done2", int'(bus.calc_done), 0);
        bus.windowBuffer = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0};
        calc("first_after_rst", 254);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
